// File: rtl/regpath_pkg.sv
// Shared types and constants for the register-path arbiter slice.
package regpath_pkg;

  localparam int NREQ_DEFAULT = 4;
  localparam int DW_DEFAULT   = 8;

  localparam logic ADDR_REG  = 1'b0;
  localparam logic ADDR_HOLD = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    XFER,
    CHECK
  } state_e;

endpackage

// File: rtl/regpath_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, cyclically.
module rr_pick
  import regpath_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   winner,
  output logic            valid
);

  logic found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        winner = IW'(c);
        found  = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/regpath_arbiter.sv
// Round-robin arbiter driving a shared write-then-transfer register datapath.
// Optional read-back comparator and mismatch counter: define READBACK_CHECK_EN.
module regpath_arbiter
  import regpath_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [DW-1:0]      rdata,
  output logic               busy,
  output logic               dp_wr,
  output logic               dp_addr,
  output logic [DW-1:0]      dp_din,
  input  logic [DW-1:0]      dp_dout,
  output logic               err
);

  localparam int IW = $clog2(NREQ);

  state_e          state, state_next;
  logic [IW-1:0]   ptr, idx;
  logic [IW-1:0]   pick_idx;
  logic            pick_valid;
  logic [DW-1:0]   data_q, rdata_q;
  logic [NREQ-1:0] sel;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every sequential register uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      idx     <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        idx    <= pick_idx;
        data_q <= wdata[int'(pick_idx)*DW +: DW];
        ptr    <= (int'(pick_idx) == NREQ-1) ? '0 : pick_idx + 1'b1;
      end
      if (state == CHECK) rdata_q <= dp_dout;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = WRITE;
      WRITE:   state_next = XFER;
      XFER:    state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel    = NREQ'(1) << idx;
  assign dp_din = data_q;

  // NOTE: defaults first so no branch leaves an output unassigned (no latches).
  always_comb begin
    gnt     = '0;
    ack     = '0;
    busy    = 1'b0;
    dp_wr   = 1'b0;
    dp_addr = ADDR_HOLD;
    rdata   = rdata_q;
    case (state)
      WRITE: begin
        gnt     = sel;
        busy    = 1'b1;
        dp_wr   = 1'b1;
        dp_addr = ADDR_REG;
      end
      XFER: begin
        gnt     = sel;
        busy    = 1'b1;
        dp_addr = ADDR_REG;
      end
      CHECK: begin
        gnt   = sel;
        busy  = 1'b1;
        ack   = sel;
        rdata = dp_dout;
      end
      default: ;
    endcase
  end

`ifdef READBACK_CHECK_EN
  logic       mismatch;
  logic [7:0] mismatch_cnt;

  assign mismatch = (state == CHECK) && (dp_dout != data_q);
  assign err      = mismatch;

  // Sticky count of read-back mismatches, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst)                                mismatch_cnt <= '0;
    else if (mismatch && mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_regpath_arbiter.sv
// Randomized + directed bench for regpath_arbiter against a transaction-level model.
module tb_regpath_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
`ifdef READBACK_CHECK_EN
  localparam logic CHK_ON = 1'b1;
`else
  localparam logic CHK_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*DW-1:0] wdata = '0;
  logic [NREQ-1:0]    gnt, ack;
  logic [DW-1:0]      rdata, dp_din, dp_dout;
  logic               busy, dp_wr, dp_addr, err;

  always #5 clk = ~clk;

  regpath_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .ack     (ack),
    .rdata   (rdata),
    .busy    (busy),
    .dp_wr   (dp_wr),
    .dp_addr (dp_addr),
    .dp_din  (dp_din),
    .dp_dout (dp_dout),
    .err     (err)
  );

  // Datapath stand-in; corrupt_en makes a write of 0x0F store 0xFF.
  logic          corrupt_en = 1'b0;
  logic [DW-1:0] dp_in_q, dp_out_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_in_q  <= '0;
      dp_out_q <= '0;
    end else if (dp_addr == 1'b0) begin
      if (dp_wr) dp_in_q  <= (corrupt_en && dp_din == 8'h0F) ? 8'hFF : dp_din;
      else       dp_out_q <= dp_in_q;
    end
  end
  assign dp_dout = dp_out_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: steps = cycles elapsed since the winning IDLE cycle.
  int            m_step = 0;
  int            m_idx = 0;
  int            m_ptr = 0;
  int            m_errs = 0;
  logic [DW-1:0] m_data = '0, m_rb = '0, m_din = '0, m_rdata = '0, m_dpout = '0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_step = 0; m_ptr = 0; m_idx = 0; m_errs = 0;
      m_din = '0; m_rdata = '0; m_dpout = '0;
    end else if (m_step == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (m_step == 0 && req[c]) begin
          m_idx  = c;
          m_data = wdata[c*DW +: DW];
          m_din  = m_data;
          m_ptr  = (c + 1) % NREQ;
          m_step = 1;
        end
      end
    end else if (m_step == 1) begin
      m_rb   = (corrupt_en && m_data == 8'h0F) ? 8'hFF : m_data;
      m_step = 2;
    end else if (m_step == 2) begin
      m_dpout = m_rb;
      m_step  = 3;
    end else begin
      m_rdata = m_rb;
      if (m_rb != m_data && m_errs < 255) m_errs++;
      m_step = 0;
    end
  end

  int            ack_idx[$];
  int            ack_cyc[$];
  logic [DW-1:0] ack_dat[$];
  logic [NREQ-1:0] e_gnt;

  always @(negedge clk) begin
    if (chk_en) begin
      e_gnt = (m_step != 0) ? NREQ'(1) << m_idx : '0;
      check("gnt",     gnt,     e_gnt);
      check("ack",     ack,     (m_step == 3) ? e_gnt : '0);
      check("busy",    busy,    m_step != 0);
      check("dp_wr",   dp_wr,   m_step == 1);
      check("dp_addr", dp_addr, !(m_step == 1 || m_step == 2));
      check("dp_din",  dp_din,  m_din);
      check("rdata",   rdata,   (m_step == 3) ? m_rb : m_rdata);
      check("dp_dout", dp_dout, m_dpout);
      check("err",     err,     CHK_ON && m_step == 3 && m_rb != m_data);
`ifdef READBACK_CHECK_EN
      check("mismatch_cnt", dut.mismatch_cnt, m_errs);
`endif
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) begin
          ack_idx.push_back(i);
          ack_cyc.push_back(cyc);
          ack_dat.push_back(rdata);
        end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    ack_idx.delete();
    ack_cyc.delete();
    ack_dat.delete();
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    rst    = 1'b0;

    // Reset values, pinned literally.
    check("rst_gnt", gnt, 0);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_dp_wr", dp_wr, 0);
    check("rst_dp_addr", dp_addr, 1);
    check("rst_dp_din", dp_din, 0);

    // Single transaction from reset.
    req[0] = 1'b1; wdata[7:0] = 8'h5A;
    @(negedge clk);
    check("t1_c1_wr", dp_wr, 1); check("t1_c1_addr", dp_addr, 0);
    check("t1_c1_din", dp_din, 8'h5A); check("t1_c1_gnt", gnt, 4'b0001);
    @(negedge clk);
    check("t1_c2_wr", dp_wr, 0); check("t1_c2_addr", dp_addr, 0); check("t1_c2_gnt", gnt, 4'b0001);
    @(negedge clk);
    check("t1_c3_ack", ack, 4'b0001); check("t1_c3_rdata", rdata, 8'h5A); check("t1_c3_gnt", gnt, 4'b0001);
    req[0] = 1'b0;
    @(negedge clk);
    check("t1_c4_ack", ack, 0); check("t1_c4_gnt", gnt, 0);

    // Transfer 0xC3, then stay idle.
    req[0] = 1'b1; wdata[7:0] = 8'hC3;
    repeat (3) @(negedge clk);
    req[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_wr", dp_wr, 0); check("idle_addr", dp_addr, 1); check("idle_dout", dp_dout, 8'hC3);
    end

    // All four at once.
    do_reset();
    req = 4'hF; wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 20 && ack_idx.size() < 4; i++) begin
      @(negedge clk);
      req = req & ~ack;
    end
    req = '0;
    check("all_count", ack_idx.size(), 4);
    for (int i = 0; i < 4 && i < ack_idx.size(); i++) begin
      check("all_order", ack_idx[i], i);
      check("all_data", ack_dat[i], 8'h11 * (i + 1));
      if (i > 0) check("all_spacing", ack_cyc[i] - ack_cyc[i-1], 4);
    end

    // Held requester must yield to a newcomer.
    do_reset();
    req[0] = 1'b1; wdata[7:0] = 8'hA0;
    @(negedge clk);
    req[2] = 1'b1; wdata[23:16] = 8'hB2;
    for (int i = 0; i < 20 && ack_idx.size() < 3; i++) begin
      @(negedge clk);
      if (ack[2]) req[2] = 1'b0;
    end
    req = '0;
    check("rr_count", ack_idx.size(), 3);
    if (ack_idx.size() >= 3) begin
      check("rr_first", ack_idx[0], 0);
      check("rr_second", ack_idx[1], 2);
      check("rr_third", ack_idx[2], 0);
    end

    // Reset during XFER.
    do_reset();
    req[1] = 1'b1; wdata[15:8] = 8'h77;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_ack", ack, 0); check("mid_gnt", gnt, 0); check("mid_busy", busy, 0);
    check("mid_addr", dp_addr, 1); check("mid_rdata", rdata, 0);
    rst = 1'b0;
    begin
      int waited;
      waited = 0;
      while (waited < 8 && !ack[1]) begin
        @(negedge clk);
        waited++;
      end
      check("mid_restart_lat", waited, 3);
      check("mid_restart_rdata", rdata, 8'h77);
    end
    req = '0;

    // Corrupted read-back.
    do_reset();
    corrupt_en = 1'b1;
    req[0] = 1'b1; wdata[7:0] = 8'h0F;
    repeat (3) @(negedge clk);
    check("bad_ack", ack, 4'b0001);
    check("bad_err", err, CHK_ON);
    check("bad_rdata", rdata, 8'hFF);
    req = '0;
    @(negedge clk);
    corrupt_en = 1'b0;
`ifdef READBACK_CHECK_EN
    check("bad_cnt", dut.mismatch_cnt, 1);
`endif

    // Random traffic; the compare process checks every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      corrupt_en = ($urandom_range(0, 7) == 0);
      rst        = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < NREQ; i++) begin
        logic [DW-1:0] d;
        d = ($urandom_range(0, 3) == 0) ? 8'h0F : DW'($urandom);
        if (ack[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
          wdata[i*DW +: DW] = d;
        end else if (!req[i]) begin
          wdata[i*DW +: DW] = d;
          if ($urandom_range(0, 2) == 0) req[i] = 1'b1;
        end else if (gnt[i]) begin
          wdata[i*DW +: DW] = d;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    corrupt_en = 1'b0;
    repeat (6) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
